// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register file and its
// context save/restore engine.
package regfile_pkg;

    localparam int REG_COUNT    = 32;
    localparam int DATA_WIDTH   = 64;
    localparam int ADDR_WIDTH   = 5;
    localparam int ZERO_REG_IDX = 31;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_OUT0,
        SAVE_OUT1,
        RESTORE,
        DONE
    } ctx_state_t;

endpackage

// File: rtl/regfile_ctx_engine.sv
// Exception context save/restore sequencer sitting on the register file ports.
// Save reads register pairs through ra1/ra2 and streams them out one value per
// handshake; restore accepts a stream in index order and rewrites the file
// through the write port, skipping the hardwired-zero register.
// Every output is a flop: the combinational block works out the next state and
// then derives next-cycle output values from that next state.
module regfile_ctx_engine
    import regfile_pkg::*;
#(
    parameter int N_REGS   = REG_COUNT,
    parameter int DATA_W   = DATA_WIDTH,
    parameter int ADDR_W   = ADDR_WIDTH,
    parameter int ZERO_REG = ZERO_REG_IDX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              save_req,
    input  logic              restore_req,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    output logic              we3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    // One extra bit so the restore counter can step past the last index
    // without wrapping back to zero.
    localparam int IDX_W = ADDR_W + 1;

    ctx_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [DATA_W-1:0] buf0_reg, buf0_next;
    logic [DATA_W-1:0] buf1_reg, buf1_next;

    logic              busy_next;
    logic              done_next;
    logic [ADDR_W-1:0] ra1_next;
    logic [ADDR_W-1:0] ra2_next;
    logic [ADDR_W-1:0] wa3_next;
    logic [DATA_W-1:0] wd3_next;
    logic              we3_next;
    logic              out_valid_next;
    logic [DATA_W-1:0] out_data_next;
    logic [ADDR_W-1:0] out_idx_next;
    logic              in_ready_next;

    logic              out_fire;
    logic              in_fire;
    logic [ADDR_W-1:0] pair_lo;
    logic [ADDR_W-1:0] pair_hi;

    assign out_fire = out_valid && out_ready;
    assign in_fire  = in_valid && in_ready;

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        buf0_next      = buf0_reg;
        buf1_next      = buf1_reg;
        we3_next       = 1'b0;
        wa3_next       = '0;
        wd3_next       = '0;

        case (state_reg)
            IDLE: begin
                idx_next = '0;
                // Save has priority when both requests arrive together.
                if (save_req) begin
                    state_next = SAVE_RD;
                end else if (restore_req) begin
                    state_next = RESTORE;
                end
            end
            SAVE_RD: begin
                // ra1/ra2 already point at the pair; the file reads combinationally.
                buf0_next  = rd1;
                buf1_next  = rd2;
                state_next = SAVE_OUT0;
            end
            SAVE_OUT0: begin
                if (out_fire) begin
                    state_next = SAVE_OUT1;
                end
            end
            SAVE_OUT1: begin
                if (out_fire) begin
                    if (idx_reg == IDX_W'(N_REGS - 2)) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(2);
                        state_next = SAVE_RD;
                    end
                end
            end
            RESTORE: begin
                if (in_fire) begin
                    // The zero register's beat is consumed but never written.
                    we3_next = (idx_reg != IDX_W'(ZERO_REG));
                    wa3_next = idx_reg[ADDR_W-1:0];
                    wd3_next = in_data;
                    idx_next = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(N_REGS - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                idx_next   = '0;
                state_next = IDLE;
            end
            default: begin
                idx_next   = '0;
                state_next = IDLE;
            end
        endcase

        // Outputs for the coming cycle follow from the state being entered.
        pair_lo        = idx_next[ADDR_W-1:0];
        pair_hi        = idx_next[ADDR_W-1:0] + ADDR_W'(1);

        busy_next      = (state_next != IDLE);
        done_next      = (state_next == DONE);
        in_ready_next  = (state_next == RESTORE);
        ra1_next       = '0;
        ra2_next       = '0;
        out_valid_next = 1'b0;
        out_data_next  = '0;
        out_idx_next   = '0;

        case (state_next)
            SAVE_RD: begin
                ra1_next = pair_lo;
                ra2_next = pair_hi;
            end
            SAVE_OUT0: begin
                out_valid_next = 1'b1;
                out_data_next  = buf0_next;
                out_idx_next   = pair_lo;
            end
            SAVE_OUT1: begin
                out_valid_next = 1'b1;
                out_data_next  = buf1_next;
                out_idx_next   = pair_hi;
            end
            default: begin
                out_valid_next = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any operation at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            buf0_reg  <= '0;
            buf1_reg  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ra1       <= '0;
            ra2       <= '0;
            wa3       <= '0;
            wd3       <= '0;
            we3       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            in_ready  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            buf0_reg  <= buf0_next;
            buf1_reg  <= buf1_next;
            busy      <= busy_next;
            done      <= done_next;
            ra1       <= ra1_next;
            ra2       <= ra2_next;
            wa3       <= wa3_next;
            wd3       <= wd3_next;
            we3       <= we3_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
            out_idx   <= out_idx_next;
            in_ready  <= in_ready_next;
        end
    end

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Bench for the context engine: a behavioural register file (reg i loaded
// with i) sits on the engine's ports while directed save/restore scenarios run.
module tb_regfile_ctx_engine;
    import regfile_pkg::*;

    localparam int NR = REG_COUNT;
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          save_req;
    logic          restore_req;
    logic          busy;
    logic          done;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic          we3;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    logic [DW-1:0] rf [NR];
    logic          rf_init;

    int pass_cnt  = 0;
    int total_cnt = 0;

    wire any_out = busy | done | we3 | out_valid | in_ready | (|ra1) | (|ra2)
                 | (|wa3) | (|wd3) | (|out_data) | (|out_idx);

    always #5 clk = ~clk;

    regfile_ctx_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .save_req    (save_req),
        .restore_req (restore_req),
        .busy        (busy),
        .done        (done),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .wa3         (wa3),
        .wd3         (wd3),
        .we3         (we3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data)
    );

    // Register file: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < NR; i++) rf[i] <= DW'(i);
        end else if (we3) begin
            rf[wa3] <= wd3;
        end
    end
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_rf;
        rf_init = 1'b1;
        tick();
        rf_init = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            save_req    = k[0];
            restore_req = k[1];
            tick();
            total_cnt++;
            if (any_out !== 1'b0) $display("FAIL reset_hold cyc%0d: outputs active=%b busy=%b, expected all 0", k, any_out, busy);
            else pass_cnt++;
        end
        save_req    = 1'b0;
        restore_req = 1'b0;
        init_rf();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if (any_out !== 1'b0) $display("FAIL reset_release cyc%0d: outputs active=%b busy=%b, expected all 0", k, any_out, busy);
            else pass_cnt++;
        end
    endtask

    task automatic test_save(input bit stall, input bit both, input string tag);
        int beats, done_cnt, we_cnt, rdy_cnt, stall_left, last_acc;
        bit finished;
        beats = 0; done_cnt = 0; we_cnt = 0; rdy_cnt = 0; last_acc = -10;
        stall_left = stall ? 4 : 0;
        finished = 1'b0;
        out_ready   = 1'b1;
        save_req    = 1'b1;
        restore_req = both;
        tick();
        save_req    = 1'b0;
        restore_req = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || ra1 !== 5'd0 || ra2 !== 5'd1 || in_ready !== 1'b0)
            $display("FAIL %s start: busy=%b ra1=%0d ra2=%0d in_ready=%b, expected 1 0 1 0", tag, busy, ra1, ra2, in_ready);
        else pass_cnt++;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            tick();
            if (we3) we_cnt++;
            if (in_ready) rdy_cnt++;
            if (done) begin
                done_cnt++;
                total_cnt++;
                if (cyc != last_acc + 1 || beats != NR)
                    $display("FAIL %s done_timing: done at cyc %0d after %0d beats, expected cyc %0d after %0d", tag, cyc, beats, last_acc + 1, NR);
                else pass_cnt++;
            end
            if (out_valid) begin
                if (stall && out_idx == AW'(5) && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    total_cnt++;
                    if (out_data !== DW'(5) || beats != 5)
                        $display("FAIL %s stall_hold: data=%0d beats=%0d, expected data 5 beats 5", tag, out_data, beats);
                    else pass_cnt++;
                end else begin
                    out_ready = 1'b1;
                    total_cnt++;
                    if (out_idx !== AW'(beats) || out_data !== DW'(beats))
                        $display("FAIL %s beat%0d: idx=%0d data=%0d, expected idx %0d data %0d", tag, beats, out_idx, out_data, beats, beats);
                    else pass_cnt++;
                    beats++;
                    last_acc = cyc;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (!busy) finished = 1'b1;
        end
        total_cnt++;
        if (!finished) $display("FAIL %s timeout: busy=%b still set, expected idle", tag, busy);
        else pass_cnt++;
        total_cnt++;
        if (beats != NR || done_cnt != 1 || we_cnt != 0 || rdy_cnt != 0 || stall_left != 0)
            $display("FAIL %s totals: beats=%0d done=%0d we3=%0d in_ready=%0d stall_left=%0d, expected %0d 1 0 0 0",
                     tag, beats, done_cnt, we_cnt, rdy_cnt, stall_left, NR);
        else pass_cnt++;
        total_cnt++;
        if (any_out !== 1'b0) $display("FAIL %s idle_outputs: active=%b, expected 0", tag, any_out);
        else pass_cnt++;
    endtask

    task automatic test_restore(input bit abort, input string tag);
        int beats, wr_exp, we_cnt, done_cnt;
        bit g3, g17, finished, abort_hit;
        beats = 0; wr_exp = 0; we_cnt = 0; done_cnt = 0;
        g3 = 1'b0; g17 = 1'b0; finished = 1'b0; abort_hit = 1'b0;
        in_valid    = 1'b0;
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL %s start: busy=%b in_ready=%b out_valid=%b, expected 1 1 0", tag, busy, in_ready, out_valid);
        else pass_cnt++;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (we3) begin
                we_cnt++;
                total_cnt++;
                if (wa3 !== AW'(wr_exp) || wd3 !== DW'(100 + wr_exp))
                    $display("FAIL %s write%0d: wa3=%0d wd3=%0d, expected %0d %0d", tag, wr_exp, wa3, wd3, wr_exp, 100 + wr_exp);
                else pass_cnt++;
                if (abort && wr_exp == 9) abort_hit = 1'b1;
                wr_exp++;
            end
            if (done) begin
                done_cnt++;
                total_cnt++;
                if (in_ready !== 1'b0) $display("FAIL %s ready_drop: in_ready=%b with done, expected 0", tag, in_ready);
                else pass_cnt++;
            end
            if (in_ready && !(abort && beats >= 10)) begin
                if (beats == 3 && !g3) begin
                    in_valid = 1'b0; g3 = 1'b1;
                end else if (beats == 17 && !g17) begin
                    in_valid = 1'b0; g17 = 1'b1;
                end else begin
                    in_valid = 1'b1;
                    in_data  = DW'(100 + beats);
                    beats++;
                end
            end else begin
                in_valid = 1'b0;
            end
            if (abort_hit) finished = 1'b1;
            else if (!abort && !busy) finished = 1'b1;
            else tick();
        end
        total_cnt++;
        if (!finished) $display("FAIL %s timeout: busy=%b writes=%0d, expected completion", tag, busy, we_cnt);
        else pass_cnt++;
        if (abort) begin
            tick();
            reset_n = 1'b0;
            #1;
            for (int k = 0; k < 3; k++) begin
                total_cnt++;
                if (any_out !== 1'b0 || done !== 1'b0)
                    $display("FAIL %s abort_outputs cyc%0d: active=%b done=%b, expected 0 0", tag, k, any_out, done);
                else pass_cnt++;
                tick();
            end
            reset_n = 1'b1;
            tick();
            total_cnt++;
            if (done_cnt != 0 || any_out !== 1'b0)
                $display("FAIL %s abort_done: done pulses=%0d active=%b, expected 0 0", tag, done_cnt, any_out);
            else pass_cnt++;
            for (int i = 0; i < NR; i++) begin
                total_cnt++;
                if (rf[i] !== ((i <= 9) ? DW'(100 + i) : DW'(i)))
                    $display("FAIL %s reg%0d: value=%0d, expected %0d", tag, i, rf[i], (i <= 9) ? 100 + i : i);
                else pass_cnt++;
            end
        end else begin
            total_cnt++;
            if (we_cnt != NR - 1 || done_cnt != 1 || beats != NR || any_out !== 1'b0)
                $display("FAIL %s totals: we3=%0d done=%0d beats=%0d active=%b, expected %0d 1 %0d 0",
                         tag, we_cnt, done_cnt, beats, any_out, NR - 1, NR);
            else pass_cnt++;
            for (int i = 0; i < NR; i++) begin
                total_cnt++;
                if (rf[i] !== ((i == ZERO_REG_IDX) ? DW'(i) : DW'(100 + i)))
                    $display("FAIL %s reg%0d: value=%0d, expected %0d", tag, i, rf[i], (i == ZERO_REG_IDX) ? i : 100 + i);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        save_req    = 1'b0;
        restore_req = 1'b0;
        out_ready   = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        rf_init     = 1'b0;
        test_reset();
        test_save(1'b0, 1'b0, "save");
        test_save(1'b1, 1'b0, "save_stall");
        test_save(1'b0, 1'b1, "priority");
        test_restore(1'b0, "restore");
        init_rf();
        test_restore(1'b1, "restore_abort");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
